// File: rtl/timer_ctrl_apb.sv
// APB3 register block and prescaler driving the 8-bit timer's control inputs.
// Holds TDR/TCR, exposes flags and count, and generates the clk_ena count strobe.
module timer_ctrl_apb #(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [7:0]  RST_TDR     = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    input  logic [7:0] tcnt,
    input  logic       overflow,
    input  logic       underflow,
    output logic [7:0] start_counter,
    output logic       load,
    output logic       up_down,
    output logic       enable,
    output logic       clk_ena,
    output logic       clr_overflow,
    output logic       clr_underflow
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam logic       WS1      = (WAIT_STATES != 0);
    localparam logic [7:0] TCR_MASK = 8'h33;

    state_t     state;
    state_t     state_nxt;
    logic       wait_cnt;
    logic [7:0] tdr;
    logic [7:0] tcr;
    logic [3:0] div_cnt;
    logic [7:0] rd_mux;
    logic       wr_fire;
    logic       rd_fire;
    logic       wr_tdr;
    logic       wr_tcr;
    logic       wr_tsr;
    logic       cks_chg;

    // True in the cycle where div_cnt[k] has just turned 1 (low bits all zero).
    function automatic logic strobe_due(input logic [3:0] cnt, input logic [1:0] k);
        logic due;
        due = 1'b0;
        case (k)
            2'd0: due = cnt[0];
            2'd1: due = (cnt[1:0] == 2'b10);
            2'd2: due = (cnt[2:0] == 3'b100);
            default: due = (cnt == 4'b1000);
        endcase
        return due;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == ACCESS) && !pready;
        end
    end

    always_comb begin
        state_nxt = state;
        pready    = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable)
                    state_nxt = SETUP;
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (wait_cnt == WS1) begin
                    pready    = 1'b1;
                    state_nxt = (psel && !penable) ? SETUP : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_fire = psel && penable && pready && pwrite;
    assign rd_fire = psel && penable && pready && !pwrite;
    assign wr_tdr  = wr_fire && (paddr == 8'h00);
    assign wr_tcr  = wr_fire && (paddr == 8'h01);
    assign wr_tsr  = wr_fire && (paddr == 8'h02);
    assign cks_chg = wr_tcr && (pwdata[1:0] != tcr[1:0]);

    always_comb begin
        rd_mux = 8'h00;
        case (paddr)
            8'h00: rd_mux = tdr;
            8'h01: rd_mux = tcr;
            8'h02: rd_mux = {6'b0, underflow, overflow};
            8'h03: rd_mux = tcnt;
            default: rd_mux = 8'h00;
        endcase
    end

    assign prdata  = rd_fire ? rd_mux : 8'h00;
    assign pslverr = pready && ((paddr > 8'h03) || ((paddr == 8'h03) && pwrite));

    // Register file and one-shot control pulses; LOAD is never stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdr           <= RST_TDR;
            tcr           <= 8'h00;
            load          <= 1'b0;
            clr_overflow  <= 1'b0;
            clr_underflow <= 1'b0;
        end else begin
            if (wr_tdr)
                tdr <= pwdata;
            if (wr_tcr)
                tcr <= pwdata & TCR_MASK;
            load          <= wr_tcr && pwdata[7];
            clr_overflow  <= wr_tsr && pwdata[0];
            clr_underflow <= wr_tsr && pwdata[1];
        end
    end

    // A CKS change restarts the divider so the new rate begins with a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 4'd0;
            clk_ena <= 1'b0;
        end else if (cks_chg) begin
            div_cnt <= 4'd0;
            clk_ena <= 1'b0;
        end else begin
            div_cnt <= div_cnt + 4'd1;
            clk_ena <= strobe_due(div_cnt, tcr[1:0]);
        end
    end

    assign start_counter = tdr;
    assign up_down       = tcr[5];
    assign enable        = tcr[4];

endmodule

// File: tb/tb_timer_ctrl_apb.sv
// Bench for timer_ctrl_apb: one instance with no wait states, one with a wait state.
// Bus responses are checked by a scoreboard monitor; side outputs inline per test.
module tb_timer_ctrl_apb;

    typedef struct {
        logic [7:0] data;
        logic       err;
    } resp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       psel0 = 1'b0;
    logic       psel1 = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] paddr = 8'h00;
    logic [7:0] pwdata = 8'h00;
    logic [7:0] tcnt = 8'h00;
    logic       overflow = 1'b0;
    logic       underflow = 1'b0;

    logic [7:0] prdata0, prdata1, start_counter0, start_counter1;
    logic       pready0, pready1, pslverr0, pslverr1;
    logic       load0, load1, up_down0, up_down1, enable0, enable1;
    logic       clk_ena0, clk_ena1, clr_ov0, clr_ov1, clr_un0, clr_un1;

    resp_t q0[$];
    resp_t q1[$];
    int    total = 0;
    int    bad = 0;

    always #5 clk = ~clk;

    timer_ctrl_apb #(.WAIT_STATES(0), .RST_TDR(8'h00)) dut0 (
        .clk(clk), .rst_n(rst_n), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
        .pslverr(pslverr0), .tcnt(tcnt), .overflow(overflow), .underflow(underflow),
        .start_counter(start_counter0), .load(load0), .up_down(up_down0),
        .enable(enable0), .clk_ena(clk_ena0), .clr_overflow(clr_ov0),
        .clr_underflow(clr_un0)
    );

    timer_ctrl_apb #(.WAIT_STATES(1), .RST_TDR(8'h00)) dut1 (
        .clk(clk), .rst_n(rst_n), .psel(psel1), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata1), .pready(pready1),
        .pslverr(pslverr1), .tcnt(tcnt), .overflow(overflow), .underflow(underflow),
        .start_counter(start_counter1), .load(load1), .up_down(up_down1),
        .enable(enable1), .clk_ena(clk_ena1), .clr_overflow(clr_ov1),
        .clr_underflow(clr_un1)
    );

    // Scoreboard: pop the expected response whenever a selected DUT completes a transfer.
    always @(negedge clk) begin
        resp_t e;
        if (psel0 && penable && pready0) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL sb0_unexpected addr=%02h", paddr);
            end else begin
                e = q0.pop_front();
                if (prdata0 !== e.data || pslverr0 !== e.err) begin
                    bad++;
                    $display("FAIL sb0_resp addr=%02h got data=%02h err=%b want data=%02h err=%b",
                             paddr, prdata0, pslverr0, e.data, e.err);
                end
            end
        end
        if (psel1 && penable && pready1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL sb1_unexpected addr=%02h", paddr);
            end else begin
                e = q1.pop_front();
                if (prdata1 !== e.data || pslverr1 !== e.err) begin
                    bad++;
                    $display("FAIL sb1_resp addr=%02h got data=%02h err=%b want data=%02h err=%b",
                             paddr, prdata1, pslverr1, e.data, e.err);
                end
            end
        end
    end

    // Drives one APB transfer; expected response is queued before the bus is driven.
    task automatic apb_xfer(input int d, input logic wr, input logic [7:0] addr,
                            input logic [7:0] wdata, input logic [7:0] exp_data,
                            input logic exp_err, output int waits);
        logic got;
        if (d == 0) q0.push_back('{exp_data, exp_err});
        else        q1.push_back('{exp_data, exp_err});
        @(posedge clk); #1;
        psel0 = (d == 0); psel1 = (d != 0);
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        got = 1'b0;
        while (!got && waits < 10) begin
            @(negedge clk);
            if ((d == 0) ? pready0 : pready1) got = 1'b1;
            else waits++;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL apb_timeout dut=%0d addr=%02h got no pready want pready within 10", d, addr);
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end
        @(posedge clk); #1;
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        int w;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({prdata0, pready0, load0, enable0, clk_ena0, up_down0, clr_ov0, clr_un0} !== 15'h0) begin
            bad++;
            $display("FAIL reset_outputs got prdata=%02h pready=%b load=%b en=%b ce=%b ud=%b co=%b cu=%b want all 0",
                     prdata0, pready0, load0, enable0, clk_ena0, up_down0, clr_ov0, clr_un0);
        end
        total++;
        if (start_counter0 !== 8'h00 || start_counter1 !== 8'h00) begin
            bad++;
            $display("FAIL reset_start got %02h/%02h want 00/00", start_counter0, start_counter1);
        end
        apb_xfer(0, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, w);
        apb_xfer(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, w);
        apb_xfer(0, 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, w);
    endtask

    task automatic test_write_load();
        int w;
        apb_xfer(0, 1'b1, 8'h00, 8'hA5, 8'h00, 1'b0, w);
        @(negedge clk);
        total++;
        if (start_counter0 !== 8'hA5 || load0 !== 1'b0) begin
            bad++;
            $display("FAIL tdr_write got start=%02h load=%b want A5 0", start_counter0, load0);
        end
        apb_xfer(0, 1'b1, 8'h01, 8'hB0, 8'h00, 1'b0, w);
        @(negedge clk);
        total++;
        if (load0 !== 1'b1 || start_counter0 !== 8'hA5 || up_down0 !== 1'b1 || enable0 !== 1'b1) begin
            bad++;
            $display("FAIL load_pulse got load=%b start=%02h ud=%b en=%b want 1 A5 1 1",
                     load0, start_counter0, up_down0, enable0);
        end
        @(negedge clk);
        total++;
        if (load0 !== 1'b0) begin
            bad++;
            $display("FAIL load_width got load=%b want 0 on second cycle", load0);
        end
        apb_xfer(0, 1'b0, 8'h01, 8'h00, 8'h30, 1'b0, w);
        // Repeat the same LOAD write: it must give its own pulse again.
        apb_xfer(0, 1'b1, 8'h01, 8'hB0, 8'h00, 1'b0, w);
        @(negedge clk);
        total++;
        if (load0 !== 1'b1) begin
            bad++;
            $display("FAIL load_repeat got load=%b want 1", load0);
        end
        apb_xfer(0, 1'b1, 8'h01, 8'h30, 8'h00, 1'b0, w);
        @(negedge clk);
        total++;
        if (load0 !== 1'b0) begin
            bad++;
            $display("FAIL load_nolo got load=%b want 0", load0);
        end
    endtask

    task automatic test_prescaler();
        int w, n;
        for (int k = 0; k < 4; k++) begin
            apb_xfer(0, 1'b1, 8'h01, 8'h30 | 8'(k), 8'h00, 1'b0, w);
            n = 0;
            do begin @(negedge clk); n++; end while (!clk_ena0 && n < 40);
            total++;
            if (!clk_ena0) begin
                bad++;
                $display("FAIL presc_first cks=%0d got no strobe want strobe within 40", k);
            end
            for (int i = 0; i < 8; i++) begin
                n = 0;
                do begin @(negedge clk); n++; end while (!clk_ena0 && n < 40);
                total++;
                if (n != (2 << k)) begin
                    bad++;
                    $display("FAIL presc_period cks=%0d strobe=%0d got %0d want %0d", k, i, n, 2 << k);
                end
            end
        end
        // CKS 3 -> 1: count clocks from the write cycle to the first new strobe.
        apb_xfer(0, 1'b1, 8'h01, 8'h31, 8'h00, 1'b0, w);
        n = 1;
        @(negedge clk);
        while (!clk_ena0 && n < 40) begin @(negedge clk); n++; end
        total++;
        if (n < 4 || !clk_ena0) begin
            bad++;
            $display("FAIL presc_switch got first strobe at %0d clocks want >= 4", n);
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!clk_ena0 && n < 40);
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL presc_switch_period got %0d want 4", n);
        end
    endtask

    task automatic test_flags();
        int w;
        logic [7:0] v;
        overflow = 1'b1;
        underflow = 1'b1;
        apb_xfer(0, 1'b0, 8'h02, 8'h00, 8'h03, 1'b0, w);
        for (int i = 0; i < 3; i++) begin
            v = (i == 0) ? 8'h01 : (i == 1) ? 8'h02 : 8'h00;
            apb_xfer(0, 1'b1, 8'h02, v, 8'h00, 1'b0, w);
            @(negedge clk);
            total++;
            if (clr_ov0 !== v[0] || clr_un0 !== v[1]) begin
                bad++;
                $display("FAIL tsr_pulse wr=%02h got co=%b cu=%b want co=%b cu=%b",
                         v, clr_ov0, clr_un0, v[0], v[1]);
            end
            @(negedge clk);
            total++;
            if (clr_ov0 !== 1'b0 || clr_un0 !== 1'b0) begin
                bad++;
                $display("FAIL tsr_width wr=%02h got co=%b cu=%b want 0 0", v, clr_ov0, clr_un0);
            end
        end
        overflow = 1'b0;
        underflow = 1'b0;
    endtask

    task automatic test_errors();
        int w;
        apb_xfer(0, 1'b1, 8'h03, 8'h55, 8'h00, 1'b1, w);
        apb_xfer(0, 1'b1, 8'h07, 8'h55, 8'h00, 1'b1, w);
        apb_xfer(0, 1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, w);
        apb_xfer(0, 1'b0, 8'h01, 8'h00, 8'h31, 1'b0, w);
        apb_xfer(0, 1'b0, 8'h07, 8'h00, 8'h00, 1'b1, w);
        tcnt = 8'h7E;
        apb_xfer(0, 1'b0, 8'h03, 8'h00, 8'h7E, 1'b0, w);
        total++;
        if (start_counter0 !== 8'hA5 || load0 !== 1'b0) begin
            bad++;
            $display("FAIL err_side got start=%02h load=%b want A5 0", start_counter0, load0);
        end
    endtask

    task automatic test_wait_states();
        int w;
        logic seen;
        apb_xfer(1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, w);
        total++;
        if (w != 2) begin
            bad++;
            $display("FAIL ws1_waits got %0d want 2", w);
        end
        apb_xfer(0, 1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, w);
        total++;
        if (w != 1) begin
            bad++;
            $display("FAIL ws0_waits got %0d want 1", w);
        end
        // TCR write to the wait-state instance, aborted by reset in its first ACCESS cycle.
        @(posedge clk); #1;
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'hB0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        total++;
        if (pready1 !== 1'b0) begin
            bad++;
            $display("FAIL ws1_setup_pready got %b want 0", pready1);
        end
        @(negedge clk);
        total++;
        if (pready1 !== 1'b0) begin
            bad++;
            $display("FAIL ws1_access_pready got %b want 0", pready1);
        end
        #1 rst_n = 1'b0;
        #1 psel1 = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (load1 !== 1'b0 || enable1 !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL abort_side got load/enable high want both 0");
        end
        apb_xfer(1, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, w);
    endtask

    initial begin
        test_reset();
        test_write_load();
        test_prescaler();
        test_flags();
        test_errors();
        test_wait_states();
        repeat (2) @(negedge clk);
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got %0d/%0d pending want 0/0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
